stream_mux: RTL
===============

STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter WIDTH, default 8: data width per channel, in bits.
REQ-002 Parameter N, default 4: number of input channels (N >= 2).
REQ-003 Parameter SELW, default 2: select and index width; must satisfy 2**SELW >= N.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 in_data  input  N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N: per-channel valid.
REQ-008 in_ready  output  N: per-channel ready (combinational).
REQ-009 mode  input  1: 0 = fixed select, 1 = round-robin.
REQ-010 select  input  SELW: channel index used in fixed mode.
REQ-011 out_data  output  WIDTH: registered output data.
REQ-012 out_valid  output  1: registered output valid.
REQ-013 out_ready  input  1: downstream ready.
REQ-014 out_sel  output  SELW: registered index of the channel that supplied out_data.

Function
REQ-015 A transfer on any port SHALL occur only in a cycle where that port's valid and ready are both high at the rising edge.
REQ-016 load_en SHALL equal (!out_valid | out_ready), giving one output register stage and full throughput of one word per cycle.
REQ-017 Fixed mode: the grant SHALL be channel `select` if select < N and in_valid[select] = 1; otherwise there SHALL be no grant.
REQ-018 Fixed mode: a select value >= N SHALL grant nothing, and all in_ready SHALL be 0.
REQ-019 Round-robin mode: the grant SHALL be the first channel with in_valid = 1, searching upward from pointer ptr and wrapping from N-1 to 0.
REQ-020 Round-robin mode: if no channel is valid there SHALL be no grant.
REQ-021 in_ready[i] SHALL be load_en AND (a grant exists) AND (grant == i); at most one in_ready bit is high in any cycle.
REQ-022 On a granted transfer, the register SHALL capture out_data <= granted channel's data, out_sel <= grant, and out_valid <= 1.
REQ-023 If load_en = 1 and there is no grant, out_valid SHALL become 0 and out_data and out_sel SHALL hold their values.
REQ-024 If load_en = 0 (out_valid = 1, out_ready = 0), out_data, out_sel and out_valid SHALL hold; no input SHALL be accepted.
REQ-025 Latency SHALL be 1 cycle from input acceptance to out_valid.
REQ-026 Back-to-back transfers SHALL be possible every cycle while out_ready stays high.
REQ-027 ptr (SELW bits) SHALL update to (grant+1) mod N only on a round-robin-mode transfer; it wraps from N-1 to 0.
REQ-028 ptr SHALL NOT change on fixed-mode transfers or in idle cycles.
REQ-029 A change of mode or select SHALL take effect combinationally in the same cycle; data already held in the output register is unaffected.
REQ-030 A channel SHALL never be granted while its in_valid = 0, in either mode.

Reset
REQ-031 While rst = 1, out_valid = 0, out_data = 0, out_sel = 0 and ptr = 0, asynchronously, independent of clk.
REQ-032 Assertion of rst mid-operation SHALL discard any held output word; no in_ready may be high while rst = 1.
REQ-033 After rst deasserts, the first grant in round-robin mode SHALL search starting from channel 0.

Verification
REQ-034 Fixed mode, select = 2, all channels valid with data 0x10,0x11,0x12,0x13, out_ready = 1 -> in_ready = 4'b0100; next cycle out_data = 0x12, out_sel = 2, out_valid = 1.
REQ-035 Fixed mode, select = 1, in_valid = 4'b1101 -> in_ready = 0 and out_valid falls to 0 after any held word drains.
REQ-036 Round-robin after reset, all valid, out_ready = 1 for 6 cycles -> out_sel sequence is 0,1,2,3,0,1 on consecutive cycles with no bubbles.
REQ-037 Round-robin, in_valid = 4'b1010, ptr = 2 -> grant 3, then ptr = 0, then grant 1.
REQ-038 Output holding 0xAB with out_ready = 0 for 3 cycles while inputs are valid -> out_data stays 0xAB, in_ready = 0; when out_ready rises, the next word loads in that same cycle.
REQ-039 rst pulsed while out_valid = 1, asynchronous to clk -> out_valid, out_data and out_sel go to 0 immediately; the first round-robin grant after release is the lowest valid channel at or above 0.

Source files
------------

// File: rtl/stream_mux.sv
// N-to-1 valid/ready stream multiplexer with a single registered output stage.
// Arbitration is either a fixed channel select or a round-robin search from a rotating pointer.
module stream_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      select,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_sel
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_en_s;
  logic             fix_found_s;
  logic             rr_found_s;
  logic [SELW-1:0]  rr_grant_s;
  logic [SELW:0]    cand_s;
  logic             grant_found_s;
  logic [SELW-1:0]  grant_s;
  logic [WIDTH-1:0] gdata_s;

  assign load_en_s = ~out_valid_q | out_ready;

  // fixed-select grant: out-of-range selects never grant
  always_comb begin
    fix_found_s = 1'b0;
    if ({1'b0, select} < (SELW+1)'(N)) begin
      fix_found_s = in_valid[select];
    end else begin
      fix_found_s = 1'b0;
    end
  end

  // round-robin grant: first valid channel at or above ptr, wrapping past N-1
  always_comb begin
    rr_found_s = 1'b0;
    rr_grant_s = '0;
    cand_s     = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, ptr_q} + (SELW+1)'(k);
      if (cand_s >= (SELW+1)'(N)) begin
        cand_s = cand_s - (SELW+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!rr_found_s && (cand_s < (SELW+1)'(N)) && in_valid[cand_s[SELW-1:0]]) begin
        rr_found_s = 1'b1;
        rr_grant_s = cand_s[SELW-1:0];
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // grant selection, granted data mux and per-channel ready
  always_comb begin
    if (mode) begin
      grant_found_s = rr_found_s;
      grant_s       = rr_grant_s;
    end else begin
      grant_found_s = fix_found_s;
      grant_s       = select;
    end
    gdata_s  = in_data[WIDTH-1:0];
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      gdata_s     = (grant_s == SELW'(i)) ? in_data[i*WIDTH +: WIDTH] : gdata_s;
      in_ready[i] = ~rst & load_en_s & grant_found_s & (grant_s == SELW'(i));
    end
  end

  // output register and pointer next state
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en_s) begin
      if (grant_found_s) begin
        out_data_d  = gdata_s;
        out_sel_d   = grant_s;
        out_valid_d = 1'b1;
        if (mode) begin
          ptr_d = (grant_s == SELW'(N-1)) ? '0 : grant_s + SELW'(1);
        end else begin
          ptr_d = ptr_q;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule
